// File: rtl/sreg_pkg.sv
// Shared definitions for the AXI-Lite to register-strobe bridge and its register slaves.
package sreg_pkg;

  localparam int SREG_AW = 18;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RD    = 3'd3,
    RRESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic RR_WRITE = 1'b0;
  localparam logic RR_READ  = 1'b1;

endpackage

// File: rtl/axil_wchan_capture.sv
// AXI-Lite write-channel capture: AW and W held independently until the owner clears them.
module axil_wchan_capture #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic [AW-1:0]   awaddr_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wstrb_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic            aw_cap_o,
  output logic            w_cap_o,
  output logic            aw_held_o,
  output logic            w_held_o,
  output logic [AW-1:0]   awaddr_o,
  output logic [DW-1:0]   wdata_o,
  output logic [DW/8-1:0] wstrb_o
);

  logic            aw_held_q, w_held_q;
  logic [AW-1:0]   awaddr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;

  assign awready_o = en_i && !aw_held_q;
  assign wready_o  = en_i && !w_held_q;
  assign aw_cap_o  = awvalid_i && awready_o;
  assign w_cap_o   = wvalid_i && wready_o;
  assign aw_held_o = aw_held_q;
  assign w_held_o  = w_held_q;
  assign awaddr_o  = awaddr_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (clr_i) aw_held_q <= 1'b0;
      else if (aw_cap_o) begin
        aw_held_q <= 1'b1;
        awaddr_q  <= awaddr_i;
      end
      if (clr_i) w_held_q <= 1'b0;
      else if (w_cap_o) begin
        w_held_q <= 1'b1;
        wdata_q  <= wdata_i;
        wstrb_q  <= wstrb_i;
      end
    end
  end

endmodule

// File: rtl/axil2sreg_master.sv
// AXI4-Lite slave bridged onto the register strobe bus, one access outstanding at a time.
// Define AXIL2SREG_DECERR_EN to reject addresses outside the BASE_ADDR window with DECERR.
module axil2sreg_master
  import sreg_pkg::*;
#(
  parameter int                AXI_AW    = 32,
  parameter int                SREG_AW   = sreg_pkg::SREG_AW,
  parameter int                RD_LAT    = 0,
  parameter logic [AXI_AW-1:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AXI_AW-1:0]  s_awaddr,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [31:0]        s_wdata,
  input  logic [3:0]         s_wstrb,
  input  logic               s_wvalid,
  output logic               s_wready,
  output logic [1:0]         s_bresp,
  output logic               s_bvalid,
  input  logic               s_bready,
  input  logic [AXI_AW-1:0]  s_araddr,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [31:0]        s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rvalid,
  input  logic               s_rready,
  output logic               sreg_en,
  output logic               sreg_wen,
  output logic [SREG_AW-1:0] sreg_addr,
  output logic [31:0]        sreg_din,
  input  logic [31:0]        sreg_dout
);

  localparam logic [1:0] RD_LAST = 2'(RD_LAT);

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [AXI_AW-1:0] ar_addr_q;
  logic [31:0]       rdata_q;
  logic [1:0]        bresp_q, rresp_q;

  logic              idle, aw_cap, w_cap, aw_held, w_held;
  logic [AXI_AW-1:0] aw_addr_h, addr_sel;
  logic [31:0]       wdata_h;
  logic [3:0]        wstrb_h;
  logic              wr_rdy, wr_part, rd_rdy, rd_last, strb_full, wr_ok, rd_ok;
  logic              grant_rd;

  assign idle = (state_q == IDLE) && !rst;

  axil_wchan_capture #(.AW(AXI_AW), .DW(32)) u_wcap (
    .clk       (clk),
    .rst       (rst),
    .en_i      (idle),
    .clr_i     (state_q == WRESP && s_bready),
    .awaddr_i  (s_awaddr),
    .awvalid_i (s_awvalid),
    .awready_o (s_awready),
    .wdata_i   (s_wdata),
    .wstrb_i   (s_wstrb),
    .wvalid_i  (s_wvalid),
    .wready_o  (s_wready),
    .aw_cap_o  (aw_cap),
    .w_cap_o   (w_cap),
    .aw_held_o (aw_held),
    .w_held_o  (w_held),
    .awaddr_o  (aw_addr_h),
    .wdata_o   (wdata_h),
    .wstrb_o   (wstrb_h)
  );

  // A write counts as ready on the cycle its last half is captured, so it can win arbitration then.
  assign wr_rdy    = (aw_held || aw_cap) && (w_held || w_cap);
  assign wr_part   = (aw_held || aw_cap || w_held || w_cap) && !wr_rdy;
  assign rd_rdy    = s_arvalid && !wr_part;
  assign rd_last   = (cnt_q == RD_LAST);
  assign strb_full = (wstrb_h == 4'hF);

`ifdef AXIL2SREG_DECERR_EN
  assign wr_ok = (aw_addr_h[AXI_AW-1:SREG_AW] == BASE_ADDR[AXI_AW-1:SREG_AW]);
  assign rd_ok = (ar_addr_q[AXI_AW-1:SREG_AW] == BASE_ADDR[AXI_AW-1:SREG_AW]);
`else
  logic unused_base;
  assign unused_base = ^BASE_ADDR;
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  logic unused_addr;
  assign unused_addr = ^{aw_addr_h[AXI_AW-1:SREG_AW], aw_addr_h[1:0],
                         ar_addr_q[AXI_AW-1:SREG_AW], ar_addr_q[1:0]};

  assign addr_sel  = (state_q == RD) ? ar_addr_q : aw_addr_h;
  assign sreg_addr = {addr_sel[SREG_AW-1:2], 2'b00};
  assign sreg_din  = wdata_h;
  assign s_arready = grant_rd;
  assign s_bvalid  = (state_q == WRESP);
  assign s_rvalid  = (state_q == RRESP);
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    grant_rd  = 1'b0;
    sreg_en   = 1'b0;
    sreg_wen  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst) begin
          if (wr_rdy && (!rd_rdy || rr_last_q == RR_READ)) begin
            state_d   = WR;
            rr_last_d = RR_WRITE;
          end else if (rd_rdy) begin
            grant_rd  = 1'b1;
            state_d   = RD;
            rr_last_d = RR_READ;
            cnt_d     = 2'd0;
          end
        end
      end
      WR: begin
        sreg_en  = wr_ok && strb_full;
        sreg_wen = wr_ok && strb_full;
        state_d  = WRESP;
      end
      WRESP: if (s_bready) state_d = IDLE;
      RD: begin
        sreg_en = rd_ok;
        cnt_d   = cnt_q + 2'd1;
        if (rd_last) state_d = RRESP;
      end
      RRESP: if (s_rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= RR_READ;
      cnt_q     <= 2'd0;
      ar_addr_q <= '0;
      rdata_q   <= '0;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      if (grant_rd) ar_addr_q <= s_araddr;
      if (state_q == WR)
        bresp_q <= !wr_ok ? RESP_DECERR : (!strb_full ? RESP_SLVERR : RESP_OKAY);
      if (state_q == RD && rd_last) begin
        rdata_q <= rd_ok ? sreg_dout : 32'h0;
        rresp_q <= rd_ok ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

endmodule
